// File: rtl/int_status_ctrl.sv
// int_status_ctrl: interrupt entry/exit sequencer in front of the status register.
// Flushes the pipeline on interrupt entry and snapshots the CCR onto a small
// shadow stack. On RTI it replays the top snapshot through the restore path.
module int_status_ctrl #(
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       intReq,
  input  logic       isRti,
  input  logic       stall,
  input  logic [3:0] statusFlags,
  output logic       flush,
  output logic       intAck,
  output logic       updateStatus,
  output logic [1:0] carryFlag,
  output logic [3:0] savedStatus,
  output logic       busy,
  output logic       errUnderflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [DW-1:0] DEPTH_MAX   = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE   = DW'(1);
  localparam logic [CW-1:0] CNT_INIT    = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [3:0]    EMPTY_FLAGS = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FLUSH   = 2'd1,
    S_SAVE    = 2'd2,
    S_RESTORE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   depth_q, depth_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic            err_q, err_d;
  logic [3:0]      stack_q [DEPTH];
  logic [3:0]      stack_d [DEPTH];
  logic            pend;
  logic [3:0]      top_flags;

  // Next-state logic: sequencing, stack push/pop, pending latch and underflow flag.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    stack_d = stack_q;
    pend    = pend_q | intReq;
    // A live request in the SAVE cycle is a new interrupt, so it re-arms the latch.
    pend_d  = intReq | (pend_q & (state_q != S_SAVE));

    case (state_q)
      S_IDLE: begin
        if (!stall) begin
          if (isRti) begin
            if (depth_q != '0) begin
              state_d = S_RESTORE;
            end else begin
              err_d = 1'b1;
            end
          end else if (pend && (depth_q < DEPTH_MAX)) begin
            state_d = S_FLUSH;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          if (cnt_q == '0) begin
            state_d = S_SAVE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      S_SAVE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (DW'(i) == depth_q) begin
            stack_d[i] = statusFlags;
          end
        end
        depth_d = depth_q + DEPTH_ONE;
        state_d = S_IDLE;
      end
      S_RESTORE: begin
        depth_d = depth_q - DEPTH_ONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      depth_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= EMPTY_FLAGS;
      end
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      stack_q <= stack_d;
    end
  end

  // Top-of-stack selection; the empty stack reads as a neutral CCR.
  always_comb begin
    top_flags = EMPTY_FLAGS;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i + 1) == depth_q) begin
        top_flags = stack_q[i];
      end
    end
  end

  assign flush        = (state_q == S_FLUSH);
  assign intAck       = (state_q == S_SAVE);
  assign updateStatus = (state_q == S_RESTORE);
  assign carryFlag    = (state_q == S_RESTORE) ? 2'b10 : 2'b00;
  assign savedStatus  = top_flags;
  assign busy         = (state_q != S_IDLE);
  assign errUnderflow = err_q;

endmodule
